// File: rtl/bram_dwc_down.sv
// Sequential BRAM width down-converter: one wide master access becomes N narrow
// single-port BRAM beats. Read data is reassembled through an RD_LAT-deep capture pipe.
module bram_dwc_down #(
   parameter int unsigned ADDR_BITW     = 32,
   parameter int unsigned MST_DATA_BITW = 128,
   parameter int unsigned SLV_DATA_BITW = 32,
   parameter int unsigned RD_LAT        = 1
) (
   input  logic                       Clk_CI,
   input  logic                       Rst_RBI,
   input  logic                       Req_SI,
   output logic                       Gnt_SO,
   input  logic [ADDR_BITW-1:0]       Addr_SI,
   input  logic                       We_SI,
   input  logic [MST_DATA_BITW/8-1:0] Be_SI,
   input  logic [MST_DATA_BITW-1:0]   Wr_DI,
   output logic                       RValid_SO,
   output logic [MST_DATA_BITW-1:0]   Rd_DO,
   output logic                       BramEn_SO,
   output logic [SLV_DATA_BITW/8-1:0] BramWe_SO,
   output logic [ADDR_BITW-1:0]       BramAddr_SO,
   output logic [SLV_DATA_BITW-1:0]   BramWr_DO,
   input  logic [SLV_DATA_BITW-1:0]   BramRd_DI
);
   localparam int unsigned N         = MST_DATA_BITW / SLV_DATA_BITW;
   localparam int unsigned SLV_BYTEW = SLV_DATA_BITW / 8;
   localparam int unsigned MST_BYTEW = MST_DATA_BITW / 8;
   localparam int unsigned CNT_W     = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DIDX_W    = (MST_DATA_BITW > 1) ? $clog2(MST_DATA_BITW) : 1;
   localparam int unsigned BIDX_W    = (MST_BYTEW > 1) ? $clog2(MST_BYTEW) : 1;
   localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(N - 1);
   localparam logic [ADDR_BITW-1:0] BASE_MASK = ~ADDR_BITW'(MST_BYTEW - 1);

   if (SLV_DATA_BITW == 0 || (SLV_DATA_BITW % 8) != 0) begin : g_err_slv_w
      $fatal(1, "bram_dwc_down: SLV_DATA_BITW must be a non-zero multiple of 8");
   end
   if (N == 0 || (N * SLV_DATA_BITW) != MST_DATA_BITW || (N & (N - 1)) != 0) begin : g_err_ratio
      $fatal(1, "bram_dwc_down: MST_DATA_BITW must be a power-of-two multiple of SLV_DATA_BITW");
   end
   if (RD_LAT < 1) begin : g_err_lat
      $fatal(1, "bram_dwc_down: RD_LAT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

   state_e                              state_q, state_d;
   logic [CNT_W-1:0]                    cnt_q, cnt_d;
   logic [ADDR_BITW-1:0]                base_q, base_d;
   logic [MST_BYTEW-1:0]                be_q, be_d;
   logic [MST_DATA_BITW-1:0]            wdata_q, wdata_d;
   logic                                en_q, en_d;
   logic [SLV_BYTEW-1:0]                bwe_q, bwe_d;
   logic [ADDR_BITW-1:0]                baddr_q, baddr_d;
   logic [SLV_DATA_BITW-1:0]            bwr_q, bwr_d;
   logic                                rvalid_q, rvalid_d;
   logic [MST_DATA_BITW-1:0]            rd_q, rd_d;
   logic [MST_DATA_BITW-1:0]            hold_q, hold_d;
   logic [RD_LAT-1:0]                   sr_vld_q, sr_vld_d;
   logic [RD_LAT-1:0][CNT_W-1:0]        sr_idx_q, sr_idx_d;

   logic                                issue, is_wr, cap, last_cap;
   logic [CNT_W-1:0]                    beat, cap_idx;
   logic [ADDR_BITW-1:0]                src_base;
   logic [MST_BYTEW-1:0]                src_be;
   logic [MST_DATA_BITW-1:0]            src_wdata;
   logic [SLV_BYTEW-1:0]                be_slice;
   logic [DIDX_W-1:0]                   d_off, cap_off;
   logic [BIDX_W-1:0]                   b_off;

   // Capture pipe: a read beat on the BRAM port retires RD_LAT cycles later.
   always_comb begin
      sr_vld_d = sr_vld_q;
      sr_idx_d = sr_idx_q;
      for (int k = RD_LAT - 1; k > 0; k--) begin
         sr_vld_d[k] = sr_vld_q[k-1];
         sr_idx_d[k] = sr_idx_q[k-1];
      end
      sr_vld_d[0] = en_q && (bwe_q == '0);
      sr_idx_d[0] = cnt_q;
   end

   always_comb begin
      cap      = sr_vld_q[RD_LAT-1];
      cap_idx  = sr_idx_q[RD_LAT-1];
      cap_off  = DIDX_W'(cap_idx) * DIDX_W'(SLV_DATA_BITW);
      last_cap = cap && (cap_idx == LAST_BEAT);
      hold_d   = hold_q;
      if (cap) begin
         hold_d[cap_off +: SLV_DATA_BITW] = BramRd_DI;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      base_d    = base_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rvalid_d  = 1'b0;
      rd_d      = rd_q;
      issue     = 1'b0;
      is_wr     = 1'b0;
      beat      = CNT_W'(cnt_q + 1'b1);
      src_base  = base_q;
      src_be    = be_q;
      src_wdata = wdata_q;

      case (state_q)
         IDLE: begin
            if (Req_SI) begin
               base_d    = Addr_SI & BASE_MASK;
               be_d      = Be_SI;
               wdata_d   = Wr_DI;
               src_base  = Addr_SI & BASE_MASK;
               src_be    = Be_SI;
               src_wdata = Wr_DI;
               beat      = '0;
               cnt_d     = '0;
               issue     = 1'b1;
               is_wr     = We_SI;
               state_d   = We_SI ? WRITE : READ;
            end
         end
         WRITE: begin
            if (cnt_q == LAST_BEAT) begin
               state_d = IDLE;
            end else begin
               cnt_d = beat;
               issue = 1'b1;
               is_wr = 1'b1;
            end
         end
         READ: begin
            if (cnt_q == LAST_BEAT) begin
               state_d = DRAIN;
            end else begin
               cnt_d = beat;
               issue = 1'b1;
            end
         end
         DRAIN: begin
            if (last_cap) begin
               state_d  = IDLE;
               rvalid_d = 1'b1;
               rd_d     = hold_d;
            end
         end
         default: state_d = IDLE;
      endcase

      // Beat output for the next cycle; address/data are zeroed while the BRAM is idle.
      d_off    = DIDX_W'(beat) * DIDX_W'(SLV_DATA_BITW);
      b_off    = BIDX_W'(beat) * BIDX_W'(SLV_BYTEW);
      be_slice = src_be[b_off +: SLV_BYTEW];
      en_d     = issue && (is_wr ? (|be_slice) : 1'b1);
      bwe_d    = (issue && is_wr) ? be_slice : '0;
      baddr_d  = en_d ? (src_base + ADDR_BITW'(beat) * ADDR_BITW'(SLV_BYTEW)) : '0;
      bwr_d    = (en_d && is_wr) ? src_wdata[d_off +: SLV_DATA_BITW] : '0;
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         base_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         en_q     <= 1'b0;
         bwe_q    <= '0;
         baddr_q  <= '0;
         bwr_q    <= '0;
         rvalid_q <= 1'b0;
         rd_q     <= '0;
         hold_q   <= '0;
         sr_vld_q <= '0;
         sr_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         en_q     <= en_d;
         bwe_q    <= bwe_d;
         baddr_q  <= baddr_d;
         bwr_q    <= bwr_d;
         rvalid_q <= rvalid_d;
         rd_q     <= rd_d;
         hold_q   <= hold_d;
         sr_vld_q <= sr_vld_d;
         sr_idx_q <= sr_idx_d;
      end
   end

   assign Gnt_SO      = (state_q == IDLE) && Rst_RBI;
   assign RValid_SO   = rvalid_q;
   assign Rd_DO       = rd_q;
   assign BramEn_SO   = en_q;
   assign BramWe_SO   = bwe_q;
   assign BramAddr_SO = baddr_q;
   assign BramWr_DO   = bwr_q;

endmodule

// File: tb/tb_bram_dwc_down.sv
// Self-checking bench for bram_dwc_down (N=4, 32-bit BRAM, RD_LAT=2) with a
// behavioural BRAM model and queue-based expected beats / read results.
module tb_bram_dwc_down;
   localparam int unsigned AW  = 32;
   localparam int unsigned MW  = 128;
   localparam int unsigned SW  = 32;
   localparam int unsigned LAT = 2;
   localparam int unsigned N   = MW / SW;

   typedef struct packed {
      logic          gnt;
      logic          en;
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [SW-1:0] wr;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic          gnt;
   logic [AW-1:0] addr = '0;
   logic          we = 1'b0;
   logic [15:0]   be = '0;
   logic [MW-1:0] wdat = '0;
   logic          rvalid;
   logic [MW-1:0] rdat;
   logic          b_en;
   logic [3:0]    b_we;
   logic [AW-1:0] b_addr;
   logic [SW-1:0] b_wr;
   logic [SW-1:0] b_rd;

   int n_checks = 0;
   int n_pass   = 0;

   beat_t         exp_beats[$];
   logic [MW-1:0] exp_rd[$];

   always #5 clk = ~clk;

   bram_dwc_down #(
      .ADDR_BITW(AW), .MST_DATA_BITW(MW), .SLV_DATA_BITW(SW), .RD_LAT(LAT)
   ) dut (
      .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Gnt_SO(gnt),
      .Addr_SI(addr), .We_SI(we), .Be_SI(be), .Wr_DI(wdat),
      .RValid_SO(rvalid), .Rd_DO(rdat),
      .BramEn_SO(b_en), .BramWe_SO(b_we), .BramAddr_SO(b_addr),
      .BramWr_DO(b_wr), .BramRd_DI(b_rd)
   );

   // BRAM model: byte-enabled writes, RD_LAT-cycle registered read path.
   logic [SW-1:0] mem [logic [AW-3:0]];
   logic [SW-1:0] rd_pipe [LAT];
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [SW-1:0] poke_data = '0;
   logic [SW-1:0] mw;

   always @(posedge clk) begin
      if (poke_en) mem[poke_addr[AW-1:2]] = poke_data;
      if (b_en) begin
         mw = mem.exists(b_addr[AW-1:2]) ? mem[b_addr[AW-1:2]] : 32'hDEAD_BEEF;
         rd_pipe[0] <= mw;
         for (int b = 0; b < 4; b++) if (b_we[b]) mw[b*8 +: 8] = b_wr[b*8 +: 8];
         if (b_we != 4'h0) mem[b_addr[AW-1:2]] = mw;
      end else begin
         rd_pipe[0] <= 32'h0BAD_0BAD;
      end
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign b_rd = rd_pipe[LAT-1];

   function automatic logic [SW-1:0] peek(input logic [AW-1:0] a);
      return mem.exists(a[AW-1:2]) ? mem[a[AW-1:2]] : 32'hDEAD_BEEF;
   endfunction

   task automatic poke(input logic [AW-1:0] a, input logic [SW-1:0] d);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Present a request and return right after the accepting edge.
   task automatic accept(input logic w, input logic [AW-1:0] a, input logic [15:0] e,
                         input logic [MW-1:0] d);
      int n;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; be = e; wdat = d;
      n = 0;
      while (!gnt && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!gnt) $display("FAIL grant_timeout actual gnt=%0b required 1", gnt);
      else n_pass++;
      @(posedge clk);
   endtask

   task automatic test_reset();
      req = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({gnt, rvalid, rdat, b_en, b_we, b_addr, b_wr} !== '0)
         $display("FAIL reset_outputs actual gnt=%0b rv=%0b rd=%h en=%0b we=%h addr=%h wr=%h required all 0",
                  gnt, rvalid, rdat, b_en, b_we, b_addr, b_wr);
      else n_pass++;
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (gnt !== 1'b1) $display("FAIL reset_release_gnt actual %0b required 1", gnt);
      else n_pass++;
   endtask

   task automatic test_write();
      logic [AW-1:0] t_addr [3];
      logic [15:0]   t_be   [3];
      logic [MW-1:0] t_dat  [3];
      t_addr = '{32'h0000_0104, 32'h0000_0400, 32'hFFFF_FFF0};
      t_be   = '{16'hFFFF, 16'h0F0F, 16'hFFFF};
      t_dat  = '{128'h44443333_22221111_00000000_FFFFFFFF,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 128'h9999AAAA_7777_8888_5555_6666_3333_4444};
      for (int c = 0; c < 3; c++) begin
         logic [AW-1:0] base;
         beat_t e, act;
         base = t_addr[c] & ~32'hF;
         for (int i = 0; i < N; i++) begin
            logic [3:0] bs;
            bs = t_be[c][i*4 +: 4];
            e.gnt  = 1'b0;
            e.en   = |bs;
            e.we   = bs;
            e.addr = e.en ? base + 32'(i * 4) : '0;
            e.wr   = e.en ? t_dat[c][i*SW +: SW] : '0;
            exp_beats.push_back(e);
         end
         e = '0;
         e.gnt = 1'b1;
         exp_beats.push_back(e);
         accept(1'b1, t_addr[c], t_be[c], t_dat[c]);
         for (int k = 1; k <= N + 1; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            act = {gnt, b_en, b_we, b_addr, b_wr};
            e = exp_beats.pop_front();
            n_checks++;
            if (act !== e)
               $display("FAIL write%0d_cycle%0d actual gnt=%0b en=%0b we=%h addr=%h wr=%h required gnt=%0b en=%0b we=%h addr=%h wr=%h",
                        c, k, act.gnt, act.en, act.we, act.addr, act.wr, e.gnt, e.en, e.we, e.addr, e.wr);
            else n_pass++;
         end
         for (int i = 0; i < N; i++) begin
            if (t_be[c][i*4 +: 4] == 4'hF) begin
               n_checks++;
               if (peek(base + 32'(i * 4)) !== t_dat[c][i*SW +: SW])
                  $display("FAIL write%0d_mem%0d actual %h required %h", c, i,
                           peek(base + 32'(i * 4)), t_dat[c][i*SW +: SW]);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic test_read(input logic [AW-1:0] a, input logic [MW-1:0] words);
      logic [AW-1:0] base;
      int pulses;
      base = a & ~32'hF;
      for (int i = 0; i < N; i++) poke(base + 32'(i * 4), words[i*SW +: SW]);
      exp_rd.push_back(words);
      accept(1'b0, a, 16'h0000, '0);
      pulses = 0;
      for (int k = 1; k <= N + LAT + 4; k++) begin
         @(negedge clk);
         if (k == 1) req = 1'b0;
         if (k <= N) begin
            n_checks++;
            if ({gnt, b_en, b_we, b_addr} !== {1'b0, 1'b1, 4'h0, base + 32'((k - 1) * 4)})
               $display("FAIL read_beat%0d actual gnt=%0b en=%0b we=%h addr=%h required gnt=0 en=1 we=0 addr=%h",
                        k - 1, gnt, b_en, b_we, b_addr, base + 32'((k - 1) * 4));
            else n_pass++;
         end
         if (rvalid) begin
            pulses++;
            n_checks++;
            if (k != N + LAT + 1 || gnt !== 1'b1)
               $display("FAIL read_rvalid_timing actual cycle=%0d gnt=%0b required cycle=%0d gnt=1",
                        k, gnt, N + LAT + 1);
            else n_pass++;
            n_checks++;
            if (exp_rd.size() == 0) $display("FAIL read_unexpected_rvalid actual pulse required none");
            else if (rdat !== exp_rd[0]) $display("FAIL read_data actual %h required %h", rdat, exp_rd.pop_front());
            else begin
               void'(exp_rd.pop_front());
               n_pass++;
            end
         end
      end
      n_checks++;
      if (pulses != 1) $display("FAIL read_pulse_count actual %0d required 1", pulses);
      else n_pass++;
      n_checks++;
      if (rdat !== words) $display("FAIL read_data_hold actual %h required %h", rdat, words);
      else n_pass++;
      exp_rd.delete();
   endtask

   task automatic test_reset_midread();
      int pulses;
      for (int i = 0; i < N; i++) poke(32'h200 + 32'(i * 4), 32'hA0A0_0000 + 32'(i));
      accept(1'b0, 32'h0000_0200, 16'h0000, '0);
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({b_en, b_addr} !== {1'b1, 32'h0000_0208})
         $display("FAIL midread_beat2 actual en=%0b addr=%h required en=1 addr=00000208", b_en, b_addr);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({gnt, rvalid, rdat, b_en, b_we, b_addr, b_wr} !== '0)
         $display("FAIL midread_reset_outputs actual gnt=%0b rv=%0b rd=%h en=%0b we=%h addr=%h wr=%h required all 0",
                  gnt, rvalid, rdat, b_en, b_we, b_addr, b_wr);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (rvalid) pulses++;
      end
      n_checks++;
      if (pulses != 0 || gnt !== 1'b1)
         $display("FAIL midread_after_release actual pulses=%0d gnt=%0b required pulses=0 gnt=1", pulses, gnt);
      else n_pass++;
      test_read(32'h0000_0300, 128'h4848_4848_3737_3737_2626_2626_1515_1515);
   endtask

   task automatic test_back_to_back();
      logic [MW-1:0] rwords, wwords;
      int k1;
      rwords = 128'hD00D_0004_C00C_0003_B00B_0002_A00A_0001;
      wwords = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
      for (int i = 0; i < N; i++) poke(32'h500 + 32'(i * 4), rwords[i*SW +: SW]);
      exp_rd.push_back(rwords);
      k1 = N + LAT + 1;
      accept(1'b0, 32'h0000_0500, 16'h0000, '0);
      for (int k = 1; k <= k1; k++) begin
         @(negedge clk);
         if (k == 1) begin
            we = 1'b1; addr = 32'h0000_0600; be = 16'hFFFF; wdat = wwords;
         end
         n_checks++;
         if (gnt !== (k == k1)) $display("FAIL b2b_gnt_cycle%0d actual %0b required %0b", k, gnt, k == k1);
         else n_pass++;
      end
      n_checks++;
      if (rvalid !== 1'b1 || rdat !== exp_rd[0])
         $display("FAIL b2b_read actual rv=%0b rd=%h required rv=1 rd=%h", rvalid, rdat, exp_rd[0]);
      else n_pass++;
      void'(exp_rd.pop_front());
      @(negedge clk);
      req = 1'b0;
      n_checks++;
      if ({gnt, b_en, b_we, b_addr, b_wr} !== {1'b0, 1'b1, 4'hF, 32'h0000_0600, wwords[SW-1:0]})
         $display("FAIL b2b_write_beat0 actual gnt=%0b en=%0b we=%h addr=%h wr=%h required gnt=0 en=1 we=f addr=00000600 wr=%h",
                  gnt, b_en, b_we, b_addr, b_wr, wwords[SW-1:0]);
      else n_pass++;
      for (int k = 2; k <= N + 1; k++) @(negedge clk);
      n_checks++;
      if ({gnt, b_en} !== 2'b10) $display("FAIL b2b_write_done actual gnt=%0b en=%0b required gnt=1 en=0", gnt, b_en);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read(32'h0000_0208, 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001);
      test_reset_midread();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/bram_dwc_down.md
# bram_dwc_down

Sequential BRAM data-width down-converter: a wide master issues one request per access over a request/grant handshake, and the block serialises it into N narrow accesses on a single-port BRAM. It covers the direction the combinational narrow-to-wide converter cannot (master wider than memory) and tolerates a configurable BRAM read latency. It sits between a wide datapath master and a narrow block-RAM port, in the memory clock domain.

## Interface
- ADDR_BITW, 32, byte-address width, same on both sides
- MST_DATA_BITW, 128, master data width; must equal N*SLV_DATA_BITW with N a power of two, N>=1
- SLV_DATA_BITW, 32, BRAM data width; must be a multiple of 8
- RD_LAT, 1, BRAM read latency in cycles, >=1
- Illegal parameter combinations: elaboration-time $fatal.

Ports:
- Clk_CI  in  1  clock, all logic on rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- Req_SI  in  1  master request
- Gnt_SO  out  1  grant; request accepted on an edge where Req_SI && Gnt_SO
- Addr_SI  in  ADDR_BITW  master byte address
- We_SI  in  1  1 = write, 0 = read
- Be_SI  in  MST_DATA_BITW/8  write byte enables, ignored for reads
- Wr_DI  in  MST_DATA_BITW  write data
- RValid_SO  out  1  read data valid, one-cycle pulse
- Rd_DO  out  MST_DATA_BITW  assembled read data
- BramEn_SO  out  1  BRAM enable
- BramWe_SO  out  SLV_DATA_BITW/8  BRAM byte write enables
- BramAddr_SO  out  ADDR_BITW  BRAM byte address
- BramWr_DO  out  SLV_DATA_BITW  BRAM write data
- BramRd_DI  in  SLV_DATA_BITW  BRAM read data

## Operation
- N = MST_DATA_BITW/SLV_DATA_BITW. Beat i carries master bits [i*SLV_DATA_BITW +: SLV_DATA_BITW], bytes [i*SLV_BYTEW +: SLV_BYTEW].
- Base address: Addr_SI with the low log2(MST_DATA_BITW/8) bits forced to 0. Beat i address = base + i*(SLV_DATA_BITW/8), modulo 2^ADDR_BITW.
- On accept, the block latches address, We, Be and data. Inputs are don't-care afterwards.
- FSM states:
  - IDLE: Gnt_SO=1. Accept with We=1 goes to WRITE; accept with We=0 goes to READ.
  - WRITE: one beat per cycle, beat counter 0..N-1.
    - BramWe_SO = Be slice. BramEn_SO = OR of the Be slice. All-zero slices still take their cycle, with En=0 and We=0.
    - After beat N-1, go to IDLE.
  - READ: one beat per cycle, BramEn_SO=1, BramWe_SO=0.
    - After beat N-1, go to DRAIN.
  - DRAIN: wait for the outstanding read data.
    - Capture is driven by an RD_LAT-deep valid/index shift register: beat i data is sampled from BramRd_DI RD_LAT cycles after its En cycle, into slice i of a holding register.
    - When the last slice is captured, go to IDLE, drive Rd_DO and pulse RValid_SO on the next cycle.
- There is no response back-pressure. The master must accept RValid_SO when it occurs.
- Rd_DO holds its value until the next read completes.
- BramAddr_SO and BramWr_DO are zero whenever BramEn_SO=0.

## Timing
- All outputs except Gnt_SO are registered. Gnt_SO = (state==IDLE) && Rst_RBI.
- Write accepted on edge closing cycle t:
  - beats occupy cycles t+1..t+N
  - Gnt_SO high again in cycle t+N+1
  - back-to-back write throughput: one access per N+1 cycles
- Read accepted on edge closing cycle t:
  - beats occupy cycles t+1..t+N
  - last data arrives in cycle t+N+RD_LAT
  - RValid_SO high in cycle t+N+RD_LAT+1, with Gnt_SO also high in that cycle
- Reset asserted (asynchronous):
  - state goes to IDLE; counters, shift register, Rd_DO, RValid_SO and all Bram* outputs go to 0; Gnt_SO=0
  - an in-flight access is abandoned and partial read data is discarded
- Reset release: Gnt_SO=1 in the first cycle after deassertion.
- Req_SI high while Gnt_SO=0 is ignored. The master holds Req_SI until granted.
- N=1: single beat. Write occupies 1 cycle. Read returns RValid_SO at t+RD_LAT+2.

## Test plan
- Write, N=4, 32-bit slave, Addr=0x104, Be=all-ones, Wr=0x44443333_22221111_00000000_FFFFFFFF -> BRAM writes at 0x100,0x104,0x108,0x10C with data FFFFFFFF,00000000,22221111,44443333 in cycles t+1..t+4; Gnt_SO low for those cycles.
- Write with Be=0x0F0F -> beats 0 and 2 have En=1 and We=0xF; beats 1 and 3 have En=0 and We=0; Gnt_SO returns at t+5.
- Read, RD_LAT=2, BRAM model preloaded with words A,B,C,D at 0x200.. -> Rd_DO={D,C,B,A} and RValid_SO pulse exactly at t+7; no other RValid_SO pulse.
- Address wrap: Addr=0xFFFFFFF0 write, N=4 -> beat addresses 0xFFFFFFF0..0xFFFFFFFC, no carry into beyond 32 bits.
- Rst_RBI pulled low during a read, at beat 2 -> all outputs 0 immediately; no RValid_SO after release; a fresh read returns correct data.
- Back-to-back read then write with Req_SI held high -> second access granted exactly in the RValid_SO cycle of the first.
